// File: rtl/bus_server.sv
// bus_server: responder end of the bus request/acknowledge protocol.
// Owns the register-file slice [ADDR_SPACE_BEGINNING, ADDR_SPACE_END].
// It takes one request at a time and inserts WAIT_STATES idle cycles.
// It then completes the write, or returns read data, with a one-cycle ack pulse.
// Optional feature macro: BUS_SERVER_ERR_EN. It adds an err output that
// flags out-of-range transactions, and makes out-of-range reads return all ones.
module bus_server #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 4,
  parameter int ADDR_SPACE_BEGINNING = 0,
  parameter int ADDR_SPACE_END       = 3,
  parameter int WAIT_STATES          = 1,
  parameter int RESET_VALUE          = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rq,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dataR,
`ifdef BUS_SERVER_ERR_EN
  output logic                  err,
`endif
  output logic                  busy
);

  localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BEGIN_A   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] RST_WORD  = DATA_WIDTH'(RESET_VALUE);
`ifdef BUS_SERVER_ERR_EN
  localparam logic [DATA_WIDTH-1:0] OOR_WORD  = {DATA_WIDTH{1'b1}};
`else
  localparam logic [DATA_WIDTH-1:0] OOR_WORD  = {DATA_WIDTH{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [3:0]              cnt_r, cnt_nxt_s;
  logic                    capture_s, complete_s;
  logic [ADDR_WIDTH-1:0]   cap_addr_r;
  logic                    cap_read_r;
  logic [DATA_WIDTH-1:0]   cap_data_r;
  logic [ADDR_WIDTH-1:0]   txn_addr_s;
  logic                    txn_read_s;
  logic [DATA_WIDTH-1:0]   txn_data_s;
  logic                    txn_in_range_s;
  logic [IDX_W-1:0]        txn_idx_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic                    ack_r, busy_r;
  logic [DATA_WIDTH-1:0]   data_r_r;
`ifdef BUS_SERVER_ERR_EN
  logic                    err_r;
`endif

  // Next-state logic: capture in IDLE, count down in WAIT (abort on rq low), single ACK cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rq) begin
          capture_s = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            state_nxt_s = ST_ACK;
            cnt_nxt_s   = 4'd0;
            complete_s  = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!rq) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd1) begin
          state_nxt_s = ST_ACK;
          cnt_nxt_s   = 4'd0;
          complete_s  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Transaction view: live inputs while capturing in IDLE (zero-wait case), captured copy otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      txn_addr_s = address;
      txn_read_s = wr_ni;
      txn_data_s = dataW;
    end else begin
      txn_addr_s = cap_addr_r;
      txn_read_s = cap_read_r;
      txn_data_s = cap_data_r;
    end
  end

  // Address decode; the offset is only meaningful when the address is inside the owned slice.
  always_comb begin
    txn_in_range_s = (int'(txn_addr_s) >= ADDR_SPACE_BEGINNING) &&
                     (int'(txn_addr_s) <= ADDR_SPACE_END);
    txn_idx_s      = IDX_W'(txn_addr_s - BEGIN_A);
    if (txn_in_range_s) begin
      rd_word_s = mem_r[txn_idx_s];
    end else begin
      rd_word_s = OOR_WORD;
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Request capture; later changes on the bus are ignored until the next capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_addr_r <= {ADDR_WIDTH{1'b0}};
      cap_read_r <= 1'b0;
      cap_data_r <= {DATA_WIDTH{1'b0}};
    end else if (capture_s) begin
      cap_addr_r <= address;
      cap_read_r <= wr_ni;
      cap_data_r <= dataW;
    end
  end

  // Storage: in-range writes land on the edge entering ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RST_WORD;
      end
    end else if (complete_s && !txn_read_s && txn_in_range_s) begin
      mem_r[txn_idx_s] <= txn_data_s;
    end
  end

  // Registered handshake outputs; dataR only changes when a read completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      data_r_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ack_r  <= complete_s;
      busy_r <= (state_nxt_s != ST_IDLE);
      if (complete_s && txn_read_s) begin
        data_r_r <= rd_word_s;
      end
    end
  end

`ifdef BUS_SERVER_ERR_EN
  // Error flag: high only in the ack cycle of an out-of-range transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= complete_s && !txn_in_range_s;
    end
  end

  assign err = err_r;
`endif

  assign ack   = ack_r;
  assign busy  = busy_r;
  assign dataR = data_r_r;

endmodule

// File: tb/tb_bus_server.sv
// Self-checking bench for bus_server.
// Three instances share clk/reset_n: WAIT_STATES = 1 (index 0), 0 (index 1) and 3 (index 2).
// A transaction-level model (word array plus last-read value) predicts ack timing and data.
module tb_bus_server;

  localparam int NI = 3;
`ifdef BUS_SERVER_ERR_EN
  localparam logic [7:0] OOR_VAL = 8'hFF;
`else
  localparam logic [7:0] OOR_VAL = 8'h00;
`endif

  logic       clk;
  logic       reset_n;
  logic       rq_s      [NI];
  logic [3:0] address_s [NI];
  logic       wr_ni_s   [NI];
  logic [7:0] dataW_s   [NI];
  logic       ack_s     [NI];
  logic [7:0] dataR_s   [NI];
  logic       busy_s    [NI];
`ifdef BUS_SERVER_ERR_EN
  logic       err_s     [NI];
`endif

  logic [7:0] mem_m     [NI][4];
  logic [7:0] last_rd_m [NI];
  int n_vec;
  int n_fail;

  bus_server #(.WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset_n(reset_n), .rq(rq_s[0]), .address(address_s[0]),
    .wr_ni(wr_ni_s[0]), .dataW(dataW_s[0]), .ack(ack_s[0]), .dataR(dataR_s[0]),
`ifdef BUS_SERVER_ERR_EN
    .err(err_s[0]),
`endif
    .busy(busy_s[0]));

  bus_server #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset_n(reset_n), .rq(rq_s[1]), .address(address_s[1]),
    .wr_ni(wr_ni_s[1]), .dataW(dataW_s[1]), .ack(ack_s[1]), .dataR(dataR_s[1]),
`ifdef BUS_SERVER_ERR_EN
    .err(err_s[1]),
`endif
    .busy(busy_s[1]));

  bus_server #(.WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .reset_n(reset_n), .rq(rq_s[2]), .address(address_s[2]),
    .wr_ni(wr_ni_s[2]), .dataW(dataW_s[2]), .ack(ack_s[2]), .dataR(dataR_s[2]),
`ifdef BUS_SERVER_ERR_EN
    .err(err_s[2]),
`endif
    .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      last_rd_m[k] = 8'h00;
      for (int w = 0; w < 4; w++) mem_m[k][w] = 8'h00;
    end
  endtask

  // Idle-state check: no ack, not busy, dataR holding the last read value.
  task automatic check_idle(input int k, input string tag);
    n_vec++;
    if (ack_s[k] !== 1'b0) begin
      n_fail++; $display("FAIL %s ack inst%0d: got %b want 0", tag, k, ack_s[k]);
    end
    n_vec++;
    if (busy_s[k] !== 1'b0) begin
      n_fail++; $display("FAIL %s busy inst%0d: got %b want 0", tag, k, busy_s[k]);
    end
    n_vec++;
    if (dataR_s[k] !== last_rd_m[k]) begin
      n_fail++; $display("FAIL %s dataR inst%0d: got %h want %h", tag, k, dataR_s[k], last_rd_m[k]);
    end
`ifdef BUS_SERVER_ERR_EN
    n_vec++;
    if (err_s[k] !== 1'b0) begin
      n_fail++; $display("FAIL %s err inst%0d: got %b want 0", tag, k, err_s[k]);
    end
`endif
  endtask

  // One full transaction with per-cycle checks of ack/busy/dataR(/err) against the model.
  task automatic do_txn(input int k, input logic [3:0] a, input logic rd,
                        input logic [7:0] d, input string tag);
    int         ws;
    logic       in_rng;
    logic       exp_ack;
    logic [7:0] exp_rd;
    logic [7:0] exp_dr;
    ws     = ws_of(k);
    in_rng = (a <= 4'd3);
    exp_rd = in_rng ? mem_m[k][a[1:0]] : OOR_VAL;
    @(negedge clk);
    rq_s[k] = 1'b1; address_s[k] = a; wr_ni_s[k] = rd; dataW_s[k] = d;
    @(posedge clk);
    for (int c = 1; c <= ws + 1; c++) begin
      @(negedge clk);
      exp_ack = (c == ws + 1);
      exp_dr  = (exp_ack && rd) ? exp_rd : last_rd_m[k];
      n_vec++;
      if (ack_s[k] !== exp_ack) begin
        n_fail++; $display("FAIL %s ack inst%0d c%0d: got %b want %b", tag, k, c, ack_s[k], exp_ack);
      end
      n_vec++;
      if (busy_s[k] !== 1'b1) begin
        n_fail++; $display("FAIL %s busy inst%0d c%0d: got %b want 1", tag, k, c, busy_s[k]);
      end
      n_vec++;
      if (dataR_s[k] !== exp_dr) begin
        n_fail++; $display("FAIL %s dataR inst%0d c%0d: got %h want %h", tag, k, c, dataR_s[k], exp_dr);
      end
`ifdef BUS_SERVER_ERR_EN
      n_vec++;
      if (err_s[k] !== (exp_ack && !in_rng)) begin
        n_fail++; $display("FAIL %s err inst%0d c%0d: got %b want %b", tag, k, c, err_s[k], exp_ack && !in_rng);
      end
`endif
      if (exp_ack) rq_s[k] = 1'b0;
      // Captured inputs may wander after capture without effect.
      address_s[k] = 4'($urandom);
      wr_ni_s[k]   = 1'($urandom);
      dataW_s[k]   = 8'($urandom);
    end
    if (rd) last_rd_m[k] = exp_rd;
    else if (in_rng) mem_m[k][a[1:0]] = d;
    @(negedge clk);
    check_idle(k, tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      rq_s[k] = 1'b0; address_s[k] = 4'd0; wr_ni_s[k] = 1'b0; dataW_s[k] = 8'd0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_idle(k, "reset");
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(0, 4'd2, 1'b1, 8'h00, "read_default");
  endtask

  task automatic test_write_read();
    do_txn(0, 4'd3, 1'b0, 8'hA5, "wr3");
    do_txn(0, 4'd3, 1'b1, 8'h00, "rd3");
    do_txn(0, 4'd0, 1'b1, 8'h00, "rd0");
  endtask

  task automatic test_back_to_back();
    logic       exp_ack;
    logic [7:0] exp_rd;
    do_txn(1, 4'd1, 1'b0, 8'h4D, "b2b_setup");
    exp_rd = mem_m[1][1];
    @(negedge clk);
    rq_s[1] = 1'b1; address_s[1] = 4'd1; wr_ni_s[1] = 1'b1; dataW_s[1] = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_ack = (c == 1) || (c == 3);
      n_vec++;
      if (ack_s[1] !== exp_ack) begin
        n_fail++; $display("FAIL b2b ack c%0d: got %b want %b", c, ack_s[1], exp_ack);
      end
      n_vec++;
      if (busy_s[1] !== exp_ack) begin
        n_fail++; $display("FAIL b2b busy c%0d: got %b want %b", c, busy_s[1], exp_ack);
      end
      n_vec++;
      if (dataR_s[1] !== exp_rd) begin
        n_fail++; $display("FAIL b2b dataR c%0d: got %h want %h", c, dataR_s[1], exp_rd);
      end
      if (c == 3) rq_s[1] = 1'b0;
    end
    last_rd_m[1] = exp_rd;
  endtask

  task automatic test_abort();
    @(negedge clk);
    rq_s[2] = 1'b1; address_s[2] = 4'd1; wr_ni_s[2] = 1'b0; dataW_s[2] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy_s[2] !== 1'b1) begin
      n_fail++; $display("FAIL abort busy_wait: got %b want 1", busy_s[2]);
    end
    rq_s[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle(2, "abort");
    end
    do_txn(2, 4'd1, 1'b1, 8'h00, "abort_rd1");
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < NI; k++) begin
      do_txn(k, 4'd9, 1'b0, 8'h77, "oor_wr9");
      do_txn(k, 4'd9, 1'b1, 8'h00, "oor_rd9");
    end
  endtask

  task automatic test_reset_mid_wait();
    do_txn(0, 4'd0, 1'b0, 8'h5A, "rst_setup");
    @(negedge clk);
    rq_s[0] = 1'b1; address_s[0] = 4'd0; wr_ni_s[0] = 1'b0; dataW_s[0] = 8'h66;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy_s[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid busy_wait: got %b want 1", busy_s[0]);
    end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) check_idle(k, "rst_mid");
    @(negedge clk);
    rq_s[0] = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_after");
    do_txn(0, 4'd0, 1'b1, 8'h00, "rst_rd0");
  endtask

  task automatic test_random();
    int         k;
    logic [3:0] a;
    logic       rd;
    for (int i = 0; i < 80; i++) begin
      k  = int'($urandom_range(0, NI - 1));
      a  = 4'($urandom_range(0, 7));
      rd = 1'($urandom);
      do_txn(k, a, rd, 8'($urandom), "random");
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
